// File: rtl/exec_unit_if.sv
// Issue and write-back bundle between an upstream issuer and the exec unit.
interface exec_unit_if;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] opcode;
    logic [2:0] rd;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       flag_z;
    logic       flag_c;
    logic       busy;

    // Issuer side: presents operations, observes write-back.
    modport master (
        output issue_valid, opcode, rd, opa, opb,
        input  issue_ready, wb_valid, wb_rd, wb_data, flag_z, flag_c, busy
    );

    // Execution side: accepts operations, produces write-back.
    modport slave (
        input  issue_valid, opcode, rd, opa, opb,
        output issue_ready, wb_valid, wb_rd, wb_data, flag_z, flag_c, busy
    );
endinterface

// File: rtl/exec_unit.sv
// 8-bit execution unit: single-cycle ALU ops plus an 8-step shift-add multiply.
module exec_unit (
    input  logic         clka,
    input  logic         reset_in,
    exec_unit_if.slave   bus
);
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_MUL = 3'b110,
        OP_MOV = 3'b111
    } op_e;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e      state, state_next;
    op_e         op;
    logic        accept;
    logic [7:0]  alu_res;
    logic        alu_c;
    logic [8:0]  alu_sum;
    logic [15:0] shl_t;

    // Multiplier working registers
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [7:0]  mplr;
    logic [2:0]  step;
    logic [2:0]  mul_rd;
    logic [15:0] prod_next;

    assign op        = op_e'(bus.opcode);
    assign accept    = (state == S_IDLE) && bus.issue_valid;
    assign prod_next = acc + (mplr[0] ? mcand : 16'd0);

    // State register
    always_ff @(posedge clka) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_in) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_next      = state;
        bus.issue_ready = 1'b0;
        bus.busy        = 1'b0;
        case (state)
            S_IDLE: begin
                bus.issue_ready = 1'b1;
                if (bus.issue_valid && op == OP_MUL) state_next = S_MUL;
            end
            S_MUL: begin
                bus.busy = 1'b1;
                if (step == 3'd7) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Single-cycle ALU result and carry
    always_comb begin
        alu_sum = {1'b0, bus.opa} + {1'b0, bus.opb};
        // The last bit shifted out of bit 7 lands in bit 8; zero shift leaves it clear.
        shl_t   = {8'd0, bus.opa} << bus.opb[2:0];
        alu_res = bus.opa;
        alu_c   = 1'b0;
        case (op)
            OP_ADD: begin alu_res = alu_sum[7:0];          alu_c = alu_sum[8];        end
            OP_SUB: begin alu_res = bus.opa - bus.opb;     alu_c = bus.opa < bus.opb; end
            OP_AND: alu_res = bus.opa & bus.opb;
            OP_OR:  alu_res = bus.opa | bus.opb;
            OP_XOR: alu_res = bus.opa ^ bus.opb;
            OP_SHL: begin alu_res = shl_t[7:0];            alu_c = shl_t[8];          end
            default: alu_res = bus.opa;
        endcase
    end

    // Write-back, flags and multiply datapath
    always_ff @(posedge clka) begin
        if (reset_in) begin
            bus.wb_valid <= 1'b0;
            bus.wb_rd    <= 3'd0;
            bus.wb_data  <= 8'h00;
            bus.flag_z   <= 1'b0;
            bus.flag_c   <= 1'b0;
            acc          <= 16'd0;
            mcand        <= 16'd0;
            mplr         <= 8'd0;
            step         <= 3'd0;
            mul_rd       <= 3'd0;
        end else begin
            bus.wb_valid <= 1'b0;
            if (accept) begin
                if (op == OP_MUL) begin
                    acc    <= 16'd0;
                    mcand  <= {8'd0, bus.opa};
                    mplr   <= bus.opb;
                    step   <= 3'd0;
                    mul_rd <= bus.rd;
                end else begin
                    bus.wb_valid <= 1'b1;
                    bus.wb_rd    <= bus.rd;
                    bus.wb_data  <= alu_res;
                    bus.flag_z   <= (alu_res == 8'h00);
                    bus.flag_c   <= alu_c;
                end
            end else if (state == S_MUL) begin
                // One partial product per cycle, regardless of operand values.
                acc   <= prod_next;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                step  <= step + 3'd1;
                if (step == 3'd7) begin
                    bus.wb_valid <= 1'b1;
                    bus.wb_rd    <= mul_rd;
                    bus.wb_data  <= prod_next[7:0];
                    bus.flag_z   <= (prod_next[7:0] == 8'h00);
                    bus.flag_c   <= (prod_next[15:8] != 8'h00);
                end
            end
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: directed vectors, decoupled monitor.
module tb_exec_unit;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, SHL = 3'b101, MUL = 3'b110, MOV = 3'b111;

    typedef struct {
        logic [2:0] rd;
        logic [7:0] data;
        logic       z;
        logic       c;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    exec_unit_if bus();

    exec_unit dut (
        .clka     (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every write-back must match the oldest expected result, on its cycle.
    always @(negedge clk) begin
        if (bus.wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_wb", 32'(bus.wb_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_cycle", 32'(cyc), 32'(e.cyc));
                check("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
                check("wb_data", 32'(bus.wb_data), 32'(e.data));
                check("flag_z", 32'(bus.flag_z), 32'(e.z));
                check("flag_c", 32'(bus.flag_c), 32'(e.c));
            end
        end
    end

    // Present an op and hold it until accepted; record the expected write-back.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_d, input logic exp_c,
                         input bit exp_wb, output int acc_cyc);
        bit done = 0;
        exp_t e;
        acc_cyc = -1;
        bus.issue_valid = 1'b1;
        bus.opcode = op;
        bus.rd = rd;
        bus.opa = a;
        bus.opb = b;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (bus.issue_ready === 1'b1 && rst == 1'b0) begin
                done = 1;
                acc_cyc = cyc;
                if (exp_wb) begin
                    e.rd = rd;
                    e.data = exp_d;
                    e.z = (exp_d == 8'h00);
                    e.c = exp_c;
                    e.cyc = cyc + ((op == MUL) ? 9 : 1);
                    sb.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
        check({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'd0);
        check({tag, "_wb_data"}, 32'(bus.wb_data), 32'd0);
        check({tag, "_flag_z"}, 32'(bus.flag_z), 32'd0);
        check({tag, "_flag_c"}, 32'(bus.flag_c), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_ready"}, 32'(bus.issue_ready), 32'd1);
    endtask

    initial begin
        int n;
        int n2;
        bus.issue_valid = 1'b0;
        bus.opcode = 3'd0;
        bus.rd = 3'd0;
        bus.opa = 8'd0;
        bus.opb = 8'd0;

        // Reset state
        wait_cycles(2);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;

        // Single-cycle ops
        issue(ADD, 3'd1, 8'hFF, 8'h01, 8'h00, 1'b1, 1, n);
        issue(SUB, 3'd5, 8'h03, 8'h05, 8'hFE, 1'b1, 1, n);
        issue(SHL, 3'd2, 8'h81, 8'h09, 8'h02, 1'b1, 1, n);
        issue(AND_, 3'd3, 8'hF0, 8'h3C, 8'h30, 1'b0, 1, n);
        issue(OR_, 3'd4, 8'h0F, 8'h30, 8'h3F, 1'b0, 1, n);
        issue(XOR_, 3'd6, 8'hAA, 8'hAA, 8'h00, 1'b0, 1, n);
        issue(MOV, 3'd7, 8'h5A, 8'h11, 8'h5A, 1'b0, 1, n);
        issue(SHL, 3'd1, 8'h81, 8'h00, 8'h81, 1'b0, 1, n);
        issue(SHL, 3'd2, 8'h01, 8'h0F, 8'h80, 1'b0, 1, n);
        issue(SHL, 3'd3, 8'h03, 8'h07, 8'h80, 1'b1, 1, n);
        issue(SUB, 3'd4, 8'h05, 8'h05, 8'h00, 1'b0, 1, n);
        idle();
        wait_cycles(2);

        // Multiply with a follow-on op held during busy
        issue(MUL, 3'd6, 8'h10, 8'h11, 8'h10, 1'b1, 1, n);
        bus.issue_valid = 1'b1;
        bus.opcode = ADD;
        bus.rd = 3'd2;
        bus.opa = 8'h20;
        bus.opb = 8'h22;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("mul_ready_low", 32'(bus.issue_ready), 32'd0);
            check("mul_busy_high", 32'(bus.busy), 32'd1);
            @(posedge clk);
            #1;
        end
        issue(ADD, 3'd2, 8'h20, 8'h22, 8'h42, 1'b0, 1, n2);
        check("held_accept_cycle", 32'(n2), 32'(n + 9));

        // Data-independent multiply latency and carry cases
        issue(MUL, 3'd1, 8'h00, 8'h55, 8'h00, 1'b0, 1, n);
        issue(MUL, 3'd3, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1, n);
        issue(MUL, 3'd5, 8'hFF, 8'hFF, 8'h01, 1'b1, 1, n);
        idle();
        wait_cycles(12);

        // Four back-to-back ADDs
        issue(ADD, 3'd0, 8'h01, 8'h02, 8'h03, 1'b0, 1, n);
        issue(ADD, 3'd1, 8'h10, 8'h20, 8'h30, 1'b0, 1, n);
        issue(ADD, 3'd2, 8'h80, 8'h80, 8'h00, 1'b1, 1, n);
        issue(ADD, 3'd3, 8'h7F, 8'h01, 8'h80, 1'b0, 1, n);
        idle();
        wait_cycles(3);

        // Reset in the middle of a multiply aborts it
        issue(MUL, 3'd4, 8'h12, 8'h34, 8'h00, 1'b0, 0, n);
        idle();
        wait_cycles(3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("abort_no_wb", 32'(bus.wb_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // An op presented alongside reset is not accepted
        rst = 1'b1;
        bus.issue_valid = 1'b1;
        bus.opcode = MOV;
        bus.rd = 3'd7;
        bus.opa = 8'h77;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("reset_op_ignored", 32'(bus.wb_valid), 32'd0);
        end
        check("reset_op_data", 32'(bus.wb_data), 32'd0);

        wait_cycles(2);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
